// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage.
//
// pat_entry_t is one pattern-table entry {en, val, mask, out}. A package
// typedef cannot follow module parameters, so val/mask/out are sized to
// MAX_IN_W / MAX_OUT_W. Modules store zero-extended values and use only
// their low IN_W / OUT_W bits. The constant upper bits are removed by
// synthesis. IN_W must not exceed MAX_IN_W, and OUT_W must not exceed
// MAX_OUT_W.
package decode_pkg;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_OUT_W = 3;
    localparam int DEF_N_PAT = 8;
    localparam int DEF_CNT_W = 16;

    localparam int MAX_IN_W  = 16;
    localparam int MAX_OUT_W = 16;

    typedef struct packed {
        logic                 en;
        logic [MAX_IN_W-1:0]  val;
        logic [MAX_IN_W-1:0]  mask;   // 1 = care bit
        logic [MAX_OUT_W-1:0] out;
    } pat_entry_t;

endpackage

// File: rtl/decode_match.sv
// Combinational pattern match and priority select.
//
// Ports:
//   in_code  [IN_W]   code to look up
//   tbl      [N_PAT]  pattern table (pat_entry_t per entry)
//   code     [OUT_W]  out field of the lowest-index matching entry, 0 if none
//   hit               at least one entry matched
//   multi             two or more entries matched
module decode_match
    import decode_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int N_PAT = DEF_N_PAT
) (
    input  logic [IN_W-1:0]  in_code,
    input  pat_entry_t       tbl [N_PAT],
    output logic [OUT_W-1:0] code,
    output logic             hit,
    output logic             multi
);

    logic [MAX_IN_W-1:0]  code_ext;
    logic [N_PAT-1:0]     match;
    logic [MAX_OUT_W-1:0] sel_out;
    logic                 unused_sel;

    assign code_ext = MAX_IN_W'(in_code);

    generate
        for (genvar gi = 0; gi < N_PAT; gi++) begin : g_match
            assign match[gi] = tbl[gi].en &&
                ((code_ext & tbl[gi].mask) == (tbl[gi].val & tbl[gi].mask));
        end
    endgenerate

    // Scan from the top down so that the lowest matching index wins.
    always_comb begin
        sel_out = '0;
        for (int i = N_PAT - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_out = tbl[i].out;
            end
        end
    end

    assign code       = sel_out[OUT_W-1:0];
    assign unused_sel = ^sel_out;
    assign hit        = |match;
    // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
    assign multi      = |(match & (match - N_PAT'(1)));

endmodule

// File: rtl/decode_stage.sv
// Pattern-decode pipeline stage with a programmable match table.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   in_valid/in_ready/in_code  input handshake and code
//   out_valid/out_ready        output handshake
//   out_code/out_hit/out_multi registered lookup result
//   cfg_we/cfg_idx/cfg_val/cfg_mask/cfg_out/cfg_en  table entry write
//   miss_cnt/multi_cnt/cnt_clr saturating event counters and their clear
//
// The lookup uses the table as it stood before the clock edge. A write
// and an accept in the same cycle therefore see the old entry.
module decode_stage
    import decode_pkg::*;
#(
    parameter  int IN_W  = DEF_IN_W,
    parameter  int OUT_W = DEF_OUT_W,
    parameter  int N_PAT = DEF_N_PAT,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int IDX_W = $clog2(N_PAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_code,
    output logic             out_hit,
    output logic             out_multi,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [IN_W-1:0]  cfg_val,
    input  logic [IN_W-1:0]  cfg_mask,
    input  logic [OUT_W-1:0] cfg_out,
    input  logic             cfg_en,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] multi_cnt,
    input  logic             cnt_clr
);

    pat_entry_t       tbl [N_PAT];
    logic [OUT_W-1:0] match_code;
    logic             match_hit;
    logic             match_multi;
    logic             accept;

    logic             out_valid_reg;
    logic [OUT_W-1:0] out_code_reg;
    logic             out_hit_reg;
    logic             out_multi_reg;
    logic [CNT_W-1:0] miss_cnt_reg;
    logic [CNT_W-1:0] multi_cnt_reg;

    // Each table entry is held in its own register. An index of N_PAT or
    // above equals no gi, so out-of-range writes are dropped. Only en is
    // reset, because a disabled entry never matches.
    generate
        for (genvar gi = 0; gi < N_PAT; gi++) begin : g_entry
            pat_entry_t entry_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg.en <= 1'b0;
                end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
                    entry_reg.en   <= cfg_en;
                    entry_reg.val  <= MAX_IN_W'(cfg_val);
                    entry_reg.mask <= MAX_IN_W'(cfg_mask);
                    entry_reg.out  <= MAX_OUT_W'(cfg_out);
                end
            end

            assign tbl[gi] = entry_reg;
        end
    endgenerate

    decode_match #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .N_PAT (N_PAT)
    ) u_match (
        .in_code (in_code),
        .tbl     (tbl),
        .code    (match_code),
        .hit     (match_hit),
        .multi   (match_multi)
    );

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Single output register. A new accept reloads it, including when the
    // current result is consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_code_reg  <= '0;
            out_hit_reg   <= 1'b0;
            out_multi_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_code_reg  <= match_code;
            out_hit_reg   <= match_hit;
            out_multi_reg <= match_multi;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Counters are updated at accept time, not when the result is consumed.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            miss_cnt_reg  <= '0;
            multi_cnt_reg <= '0;
        end else if (accept) begin
            if (!match_hit && (miss_cnt_reg != '1)) begin
                miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
            end
            if (match_multi && (multi_cnt_reg != '1)) begin
                multi_cnt_reg <= multi_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_code  = out_code_reg;
    assign out_hit   = out_hit_reg;
    assign out_multi = out_multi_reg;
    assign miss_cnt  = miss_cnt_reg;
    assign multi_cnt = multi_cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage.
// The DUT uses CNT_W=4 so that counter saturation can be reached.
// The bench pushes expected results into a queue when the DUT accepts an
// input. A negedge monitor pops and compares them when the DUT hands over
// an output.
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_hit;
    logic       out_multi;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_val;
    logic [3:0] cfg_mask;
    logic [2:0] cfg_out;
    logic       cfg_en;
    logic [3:0] miss_cnt;
    logic [3:0] multi_cnt;
    logic       cnt_clr;

    int errors   = 0;
    int n_checks = 0;

    typedef struct packed {
        logic [2:0] code;
        logic       hit;
        logic       multi;
    } exp_t;

    typedef struct {
        logic [3:0] code;
        logic [2:0] exp_code;
        logic       exp_hit;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs [16];

    always #5 clk = ~clk;

    decode_stage #(
        .IN_W  (4),
        .OUT_W (3),
        .N_PAT (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_hit   (out_hit),
        .out_multi (out_multi),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_val   (cfg_val),
        .cfg_mask  (cfg_mask),
        .cfg_out   (cfg_out),
        .cfg_en    (cfg_en),
        .miss_cnt  (miss_cnt),
        .multi_cnt (multi_cnt),
        .cnt_clr   (cnt_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Output-side monitor: every consumed output must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                errors++;
                $display("FAIL unexpected_output: got code=%0b with no result pending, required none", out_code);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn out code=%03b hit=%0b multi=%0b (required %03b %0b %0b)",
                         out_code, out_hit, out_multi, e.code, e.hit, e.multi);
                check("out_code", 32'(out_code), 32'(e.code));
                check("out_hit", 32'(out_hit), 32'(e.hit));
                check("out_multi", 32'(out_multi), 32'(e.multi));
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic program_entry(input int idx, input logic [3:0] v, input logic [3:0] m,
                                 input logic [2:0] o, input logic e);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_val  = v;
        cfg_mask = m;
        cfg_out  = o;
        cfg_en   = e;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input logic [2:0] ec, input logic eh, input logic em);
        int n = 0;
        in_valid = 1'b1;
        in_code  = c;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                n_checks++;
                errors++;
                $display("FAIL accept_timeout: code %04b not accepted after 50 cycles, required accept", c);
                break;
            end
        end
        if (n <= 50) exp_q.push_back('{ec, eh, em});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] miss_req, input logic [3:0] multi_req);
        @(negedge clk);
        check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(miss_req));
        check({tag, "_multi_cnt"}, 32'(multi_cnt), 32'(multi_req));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Exact-match table expectations: eight listed codes hit, eight miss.
        vecs[0]  = '{4'b0000, 3'b000, 1'b0};
        vecs[1]  = '{4'b0001, 3'b010, 1'b1};
        vecs[2]  = '{4'b0010, 3'b000, 1'b0};
        vecs[3]  = '{4'b0011, 3'b000, 1'b0};
        vecs[4]  = '{4'b0100, 3'b000, 1'b1};
        vecs[5]  = '{4'b0101, 3'b000, 1'b0};
        vecs[6]  = '{4'b0110, 3'b000, 1'b0};
        vecs[7]  = '{4'b0111, 3'b010, 1'b1};
        vecs[8]  = '{4'b1000, 3'b100, 1'b1};
        vecs[9]  = '{4'b1001, 3'b000, 1'b0};
        vecs[10] = '{4'b1010, 3'b000, 1'b0};
        vecs[11] = '{4'b1011, 3'b000, 1'b1};
        vecs[12] = '{4'b1100, 3'b001, 1'b1};
        vecs[13] = '{4'b1101, 3'b100, 1'b1};
        vecs[14] = '{4'b1110, 3'b000, 1'b0};
        vecs[15] = '{4'b1111, 3'b001, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_val   = '0;
        cfg_mask  = '0;
        cfg_out   = '0;
        cfg_en    = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_code", 32'(out_code), 0);
        check("rst_out_hit", 32'(out_hit), 0);
        check("rst_out_multi", 32'(out_multi), 0);
        check("rst_miss_cnt", 32'(miss_cnt), 0);
        check("rst_multi_cnt", 32'(multi_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Exact-match table, all 16 codes streamed back to back
        program_entry(0, 4'b1011, 4'b1111, 3'b000, 1'b1);
        program_entry(1, 4'b0100, 4'b1111, 3'b000, 1'b1);
        program_entry(2, 4'b1100, 4'b1111, 3'b001, 1'b1);
        program_entry(3, 4'b1111, 4'b1111, 3'b001, 1'b1);
        program_entry(4, 4'b0111, 4'b1111, 3'b010, 1'b1);
        program_entry(5, 4'b0001, 4'b1111, 3'b010, 1'b1);
        program_entry(6, 4'b1101, 4'b1111, 3'b100, 1'b1);
        program_entry(7, 4'b1000, 4'b1111, 3'b100, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].code, vecs[i].exp_code, vecs[i].exp_hit, 1'b0);
        end
        drain();
        check_cnt("table16", 4'd8, 4'd0);

        // Overlap: wildcard entry 0 beats exact entry 3
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        program_entry(0, 4'b0000, 4'b0000, 3'b011, 1'b1);
        program_entry(3, 4'b0101, 4'b1111, 3'b111, 1'b1);
        send(4'b0101, 3'b011, 1'b1, 1'b1);
        drain();
        check_cnt("overlap", 4'd0, 4'd1);

        // Rewrite entry 2 in the cycle a matching code is accepted
        program_entry(0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        in_valid = 1'b1;
        in_code  = 4'b1100;
        cfg_we   = 1'b1;
        cfg_idx  = 3'd2;
        cfg_val  = 4'b1100;
        cfg_mask = 4'b1111;
        cfg_out  = 3'b110;
        cfg_en   = 1'b1;
        @(negedge clk);
        check("wr_same_cycle_in_ready", 32'(in_ready), 1);
        exp_q.push_back('{3'b001, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        send(4'b1100, 3'b110, 1'b1, 1'b0);
        drain();

        // Backpressure: one result held for 5 cycles, no loss or duplication
        out_ready = 1'b0;
        send(4'b0101, 3'b111, 1'b1, 1'b0);
        fork
            send(4'b0111, 3'b010, 1'b1, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("hold_in_ready", 32'(in_ready), 0);
                    check("hold_out_valid", 32'(out_valid), 1);
                    check("hold_out_code", 32'(out_code), 32'(3'b111));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(4'b0000, 3'b000, 1'b0, 1'b0);
        drain();

        // Miss-counter saturation at 15, then clear beats a same-cycle miss
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(4'b0000, 3'b000, 1'b0, 1'b0);
        end
        drain();
        check_cnt("saturate", 4'd15, 4'd0);
        cnt_clr = 1'b1;
        send(4'b0000, 3'b000, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        drain();
        check_cnt("clr_priority", 4'd0, 4'd0);

        // Reset with a held result and nonzero counters; writes during reset ignored
        send(4'b0000, 3'b000, 1'b0, 1'b0);
        program_entry(0, 4'b0000, 4'b0000, 3'b011, 1'b1);
        send(4'b0101, 3'b011, 1'b1, 1'b1);
        drain();
        out_ready = 1'b0;
        send(4'b0101, 3'b011, 1'b1, 1'b1);
        @(negedge clk);
        check("pre_rst_out_valid", 32'(out_valid), 1);
        check("pre_rst_miss_cnt", 32'(miss_cnt), 1);
        check("pre_rst_multi_cnt", 32'(multi_cnt), 2);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_code  = 4'b0101;
        cfg_we   = 1'b1;
        cfg_idx  = 3'd3;
        cfg_val  = 4'b0101;
        cfg_mask = 4'b1111;
        cfg_out  = 3'b111;
        cfg_en   = 1'b1;
        cnt_clr  = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_miss_cnt", 32'(miss_cnt), 0);
        check("mid_rst_multi_cnt", 32'(multi_cnt), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'b0101, 3'b000, 1'b0, 1'b0);
        send(4'b1100, 3'b000, 1'b0, 1'b0);
        drain();
        check_cnt("post_rst", 4'd2, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameters: IN_W, default 4, input code width; OUT_W, default 3, decoded output width; N_PAT, default 8, pattern-table entries (2..32); CNT_W, default 16, error-counter width.
REQ-002 SHALL have ports: clk in 1, the single clock; reset in 1, synchronous, active-high, sampled on rising clk.
REQ-003 SHALL have port in_valid in 1: code present.
REQ-004 SHALL have port in_ready out 1: stage accepts this cycle.
REQ-005 SHALL have port in_code in IN_W: code to decode.
REQ-006 SHALL have ports out_valid out 1, out_ready in 1, out_code out OUT_W, out_hit out 1 (a pattern matched), out_multi out 1 (more than one pattern matched).
REQ-007 SHALL have table-write ports: cfg_we in 1; cfg_idx in $clog2(N_PAT); cfg_val in IN_W; cfg_mask in IN_W (1 = care bit); cfg_out in OUT_W; cfg_en in 1.
REQ-008 SHALL have counter ports: miss_cnt out CNT_W; multi_cnt out CNT_W; cnt_clr in 1.

Function
REQ-009 SHALL hold N_PAT table entries {en, val, mask, out}; entry i matches when en=1 and (in_code & mask) == (val & mask).
REQ-010 SHALL write entry cfg_idx with {cfg_en, cfg_val, cfg_mask, cfg_out} on the clk edge where cfg_we=1; cfg_idx >= N_PAT is ignored.
REQ-011 SHALL perform lookup against table contents before any same-cycle write (write-then-read takes effect next cycle).
REQ-012 SHALL, on zero matches, produce out_code = 0 and out_hit = 0, with no X on any output.
REQ-013 SHALL, on one or more matches, produce out_code of the lowest-index matching entry and out_hit = 1; out_multi = 1 when two or more entries match.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (single output register, no combinational path from in_code to outputs).
REQ-015 SHALL accept a transfer when in_valid && in_ready; the result appears on outputs with out_valid=1 on the following cycle (latency 1).
REQ-016 SHALL hold out_code/out_hit/out_multi/out_valid stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid after a consumed output (out_valid && out_ready) when no new transfer is accepted that cycle; with simultaneous accept, it loads the new result and keeps out_valid=1 (full throughput).
REQ-018 SHALL increment miss_cnt once per accepted code with no match, and multi_cnt once per accepted code with multiple matches; both saturate at all-ones.
REQ-019 SHALL zero both counters on cnt_clr; cnt_clr has priority over a same-cycle increment.

Reset
REQ-020 SHALL, on reset, set out_valid=0, out_code=0, out_hit=0, out_multi=0, miss_cnt=0, multi_cnt=0, and all table en bits = 0 (val/mask/out need not be reset).
REQ-021 SHALL discard any in-flight result on reset mid-operation; in_ready=1 in the first cycle after reset.
REQ-022 SHALL ignore cfg_we, in_valid and cnt_clr during cycles where reset=1.

Structure
REQ-023 SHALL place the table-entry struct type (en, val, mask, out) and the default-parameter constants in a shared package, decode_pkg.
REQ-024 SHALL implement the combinational match/priority logic as one sub-module, decode_match, parametrised by IN_W, OUT_W, N_PAT and returning {code, hit, multi}.

Verification
REQ-025 SHALL cover table programmed as 1011->000, 0100->000, 1100->001, 1111->001, 0111->010, 0001->010, 1101->100, 1000->100, then all 16 codes streamed -> listed codes give listed outputs with hit=1, other 8 give code 0, hit=0; miss_cnt=8.
REQ-026 SHALL cover entry 0 {val 0000, mask 0000} and entry 3 {val 0101, mask 1111, out 111}, input 0101 -> out_code = entry-0 out, out_multi=1, multi_cnt=1.
REQ-027 SHALL cover out_ready held 0 for 5 cycles with in_valid=1 -> one result held stable, in_ready=0 after the first accept, no code lost or duplicated after release.
REQ-028 SHALL cover cfg_we rewriting entry 2 in the same cycle a matching code is accepted -> result uses old entry; next code uses new entry.
REQ-029 SHALL cover reset asserted with out_valid=1 and counters nonzero -> next cycle out_valid=0, counters 0, all inputs miss (hit=0).
REQ-030 SHALL cover CNT_W=4 with 20 misses -> miss_cnt saturates at 15; cnt_clr with a same-cycle miss -> 0.
